// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: stall/flush/valid handling plus a saturating taken-branch counter.
// Optional macro EX_MEM_BRANCH_SQUASH_EN: a taken-branch departure also loads a bubble.
module ex_mem_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [1:0]  ctlwb_out,
  input  logic [2:0]  ctlm_out,
  input  logic [31:0] adder_out,
  input  logic        aluzero,
  input  logic [31:0] aluout,
  input  logic [31:0] readdat2,
  input  logic [4:0]  muxout,
  output logic [1:0]  wb_ctlout,
  output logic        m_ctlout,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  five_bit_muxout,
  output logic        valid_out,
  output logic [7:0]  taken_cnt
);

  logic [1:0]  r_wb;
  logic        r_branch;
  logic        r_memread;
  logic        r_memwrite;
  logic [31:0] r_add;
  logic        r_zero;
  logic [31:0] r_alu;
  logic [31:0] r_rdata2;
  logic [4:0]  r_rd;
  logic        r_valid;
  logic [7:0]  r_taken_cnt;

  logic        w_taken;
  logic        w_bubble;
  logic [7:0]  w_cnt_nxt;

  // The resident entry departs on any non-stalled edge, flushed or not.
  assign w_taken = ~stall & r_valid & r_branch & r_zero;

`ifdef EX_MEM_BRANCH_SQUASH_EN
  assign w_bubble = flush | w_taken;
`else
  assign w_bubble = flush;
`endif

  // Saturating taken-branch count.
  always_comb begin
    w_cnt_nxt = r_taken_cnt;
    if (w_taken && (r_taken_cnt != 8'hFF)) begin
      w_cnt_nxt = r_taken_cnt + 8'd1;
    end else begin
      w_cnt_nxt = r_taken_cnt;
    end
  end

  // Pipeline register update: rst > bubble > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb        <= 2'b00;
      r_branch    <= 1'b0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_add       <= 32'h0000_0000;
      r_zero      <= 1'b0;
      r_alu       <= 32'h0000_0000;
      r_rdata2    <= 32'h0000_0000;
      r_rd        <= 5'd0;
      r_valid     <= 1'b0;
      r_taken_cnt <= 8'h00;
    end else begin
      r_taken_cnt <= w_cnt_nxt;
      if (w_bubble) begin
        r_wb       <= 2'b00;
        r_branch   <= 1'b0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_add      <= 32'h0000_0000;
        r_zero     <= 1'b0;
        r_alu      <= 32'h0000_0000;
        r_rdata2   <= 32'h0000_0000;
        r_rd       <= 5'd0;
        r_valid    <= 1'b0;
      end else if (!stall) begin
        // An invalid instruction carries its data but never its control.
        r_wb       <= valid_in ? ctlwb_out : 2'b00;
        r_branch   <= valid_in & ctlm_out[2];
        r_memread  <= valid_in & ctlm_out[1];
        r_memwrite <= valid_in & ctlm_out[0];
        r_add      <= adder_out;
        r_zero     <= aluzero;
        r_alu      <= aluout;
        r_rdata2   <= readdat2;
        r_rd       <= muxout;
        r_valid    <= valid_in;
      end
    end
  end

  assign wb_ctlout       = r_wb;
  assign m_ctlout        = r_branch;
  assign memread         = r_memread;
  assign memwrite        = r_memwrite;
  assign add_result      = r_add;
  assign zero            = r_zero;
  assign alu_result      = r_alu;
  assign rdata2out       = r_rdata2;
  assign five_bit_muxout = r_rd;
  assign valid_out       = r_valid;
  assign taken_cnt       = r_taken_cnt;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch: stimulus pushes expected outputs, a monitor pops and compares.
module tb_ex_mem_latch;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in, aluzero;
  logic [1:0]  ctlwb_out;
  logic [2:0]  ctlm_out;
  logic [31:0] adder_out, aluout, readdat2;
  logic [4:0]  muxout;
  logic [1:0]  wb_ctlout;
  logic        m_ctlout, memread, memwrite, zero, valid_out;
  logic [31:0] add_result, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;
  logic [7:0]  taken_cnt;

  int errors = 0;
  int checks = 0;

  logic [115:0] exp_q[$];
  string        name_q[$];

  // Expected-state model
  logic [1:0]  e_wb = 2'b00;
  logic        e_br = 1'b0, e_mr = 1'b0, e_mw = 1'b0, e_zero = 1'b0, e_valid = 1'b0;
  logic [31:0] e_add = 32'h0, e_alu = 32'h0, e_rd2 = 32'h0;
  logic [4:0]  e_rd = 5'd0;
  logic [7:0]  e_cnt = 8'h00;

  always #5 clk = ~clk;

  ex_mem_latch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .adder_out(adder_out),
    .aluzero(aluzero), .aluout(aluout), .readdat2(readdat2), .muxout(muxout),
    .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .memread(memread), .memwrite(memwrite),
    .add_result(add_result), .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .five_bit_muxout(five_bit_muxout), .valid_out(valid_out), .taken_cnt(taken_cnt)
  );

  function automatic logic [115:0] exp_vec();
    return {e_wb, e_br, e_mr, e_mw, e_add, e_zero, e_alu, e_rd2, e_rd, e_valid, e_cnt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic fl, input logic v,
                       input logic [1:0] wb, input logic [2:0] m, input logic [31:0] add,
                       input logic z, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic [4:0] rd, input string nm);
    logic tk, bub;
    @(negedge clk);
    rst = r; stall = st; flush = fl; valid_in = v; ctlwb_out = wb; ctlm_out = m;
    adder_out = add; aluzero = z; aluout = alu; readdat2 = rd2; muxout = rd;
    tk = !r && !st && e_valid && e_br && e_zero;
    bub = fl;
`ifdef EX_MEM_BRANCH_SQUASH_EN
    bub = fl || tk;
`endif
    if (r) begin
      {e_wb, e_br, e_mr, e_mw, e_add, e_zero, e_alu, e_rd2, e_rd, e_valid, e_cnt} = '0;
    end else begin
      if (tk && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
      if (bub) begin
        {e_wb, e_br, e_mr, e_mw, e_add, e_zero, e_alu, e_rd2, e_rd, e_valid} = '0;
      end else if (!st) begin
        e_valid = v;
        e_wb = v ? wb : 2'b00;
        {e_br, e_mr, e_mw} = v ? m : 3'b000;
        e_add = add; e_zero = z; e_alu = alu; e_rd2 = rd2; e_rd = rd;
      end
    end
    exp_q.push_back(exp_vec());
    name_q.push_back(nm);
  endtask

  // Monitor: compare the full output bundle once per edge against the queued expectation.
  always @(posedge clk) begin
    logic [115:0] expv, act;
    string nm;
    #1;
    if (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {wb_ctlout, m_ctlout, memread, memwrite, add_result, zero, alu_result,
             rdata2out, five_bit_muxout, valid_out, taken_cnt};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; aluzero = 1'b0;
    ctlwb_out = 2'b00; ctlm_out = 3'b000; adder_out = 32'h0; aluout = 32'h0;
    readdat2 = 32'h0; muxout = 5'd0;

    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 5'd31, "reset1");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 5'd31, "reset2");
    after_edge();
    chk("reset_cnt", {24'h0, taken_cnt}, 32'h0);
    chk("reset_valid", {31'h0, valid_out}, 32'h0);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_0100, 1'b0, 32'h0000_00A5, 32'h0000_0011, 5'd9, "load");
    after_edge();
    chk("load_alu", alu_result, 32'h0000_00A5);
    chk("load_rd", {27'h0, five_bit_muxout}, 32'd9);
    chk("load_wb", {30'h0, wb_ctlout}, 32'd2);
    chk("load_valid", {31'h0, valid_out}, 32'd1);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b010, 32'h0000_0200, 1'b0, 32'h0000_0077, 32'h0000_0088, 5'd3, "stall_load");
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 3'b001, 32'h1000 + i, 1'b1, 32'hF000 + i, 32'hE000 + i, 5'd20 + 5'(i), "stall_hold");
    after_edge();
    chk("stall_alu", alu_result, 32'h0000_0077);
    chk("stall_rd", {27'h0, five_bit_muxout}, 32'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b001, 32'h0000_0300, 1'b0, 32'h0000_0123, 32'h0000_0456, 5'd12, "unstall");

    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 3'b111, 32'h0000_0400, 1'b1, 32'h0000_0999, 32'h0000_0888, 5'd15, "flush_stall");
    after_edge();
    chk("flush_valid", {31'h0, valid_out}, 32'd0);
    chk("flush_alu", alu_result, 32'd0);
    chk("flush_wb", {30'h0, wb_ctlout}, 32'd0);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b100, 32'h0000_0040, 1'b1, 32'h0, 32'h0, 5'd0, "br_load");
    after_edge();
    chk("br_m", {31'h0, m_ctlout}, 32'd1);
    chk("br_zero", {31'h0, zero}, 32'd1);
    chk("br_cnt0", {24'h0, taken_cnt}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b001, 32'h0000_0044, 1'b0, 32'h0000_0055, 32'h0000_0066, 5'd7, "after_br");
    after_edge();
    chk("br_cnt1", {24'h0, taken_cnt}, 32'd1);
`ifdef EX_MEM_BRANCH_SQUASH_EN
    chk("br_squash_valid", {31'h0, valid_out}, 32'd0);
`else
    chk("br_noquash_valid", {31'h0, valid_out}, 32'd1);
`endif

    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b111, 32'h0000_0048, 1'b1, 32'h0000_0099, 32'h0000_0011, 5'd5, "invalid");
    after_edge();
    chk("invalid_wb", {30'h0, wb_ctlout}, 32'd0);
    chk("invalid_alu", alu_result, 32'h0000_0099);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b100, 32'h0000_0080, 1'b1, 32'h1, 32'h2, 5'd1, "br_stall_load");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_0084, 1'b0, 32'h3, 32'h4, 5'd2, "br_stall1");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_0088, 1'b0, 32'h5, 32'h6, 5'd3, "br_stall2");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 32'h0000_008C, 1'b0, 32'h7, 32'h8, 5'd4, "flush_depart");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 3'b111, 32'h0000_0090, 1'b1, 32'h9, 32'hA, 5'd6, "rst_mid");

    for (int i = 0; i < 540; i++)
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b100, 32'h2000 + i, 1'b1, 32'(i), 32'h0, 5'd0, "saturate");
    after_edge();
    chk("sat_cnt", {24'h0, taken_cnt}, 32'h0000_00FF);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b100, 32'h3000, 1'b1, 32'h0, 32'h0, 5'd0, "sat_hold");
    after_edge();
    chk("sat_hold_cnt", {24'h0, taken_cnt}, 32'h0000_00FF);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
# ex_mem_latch

EX/MEM pipeline register for the five-stage MIPS core. It captures the execute-stage results and the WB/M control bundles at each clock edge and presents them to the memory stage. That includes the branch control bit and ALU zero flag that the MEM-stage branch AND gate combines into PCSrc. It supports stall (hold), flush (bubble insertion), a valid bit, and a saturating taken-branch counter.

## Interface
- No parameters; all widths fixed for the 32-bit datapath.
- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all registered contents this cycle
- flush  in  1  load a bubble this cycle
- valid_in  in  1  EX-stage instruction is valid
- ctlwb_out  in  2  WB control bundle {regwrite, memtoreg}
- ctlm_out  in  3  M control bundle {branch, memread, memwrite}
- adder_out  in  32  branch target address from EX adder
- aluzero  in  1  ALU zero flag
- aluout  in  32  ALU result
- readdat2  in  32  register-file read data 2 (store data)
- muxout  in  5  destination register number
- wb_ctlout  out  2  registered WB bundle
- m_ctlout  out  1  registered branch bit (to branch AND gate)
- memread  out  1  registered memread
- memwrite  out  1  registered memwrite
- add_result  out  32  registered branch target
- zero  out  1  registered ALU zero flag (to branch AND gate)
- alu_result  out  32  registered ALU result
- rdata2out  out  32  registered store data
- five_bit_muxout  out  5  registered destination register
- valid_out  out  1  registered entry is valid
- taken_cnt  out  8  saturating count of taken branches leaving the stage

## Operation
- Every output is driven directly from a register; there is no combinational path from input to output.
- Update priority at each rising edge: rst > flush > stall > normal load.
- rst: all outputs are cleared to 0, including taken_cnt.
- flush: every field is cleared to 0. valid_out=0, and all control bits are 0, so the result is a bubble. taken_cnt updates according to the departing entry (see below).
- stall (no flush): every field, valid_out and taken_cnt hold their values.
- Normal load: every field takes its input value, and valid_out takes valid_in.
- Departure: at an edge with stall=0 and rst=0, the current entry leaves the stage, whether or not flush is asserted.
- Taken-branch event: a departure at which valid_out=1, m_ctlout=1 and zero=1.
- taken_cnt increments by 1 on each taken-branch event and saturates at 8'hFF; it never wraps.
- Invalid entries: when valid_in=0 on a normal load, the control bits are loaded as 0. Data fields load as presented.

## Timing
- Latency is one cycle from input to output.
- PCSrc, computed downstream as m_ctlout & zero, is therefore valid one cycle after EX.
- flush and stall asserted together: flush wins and the bubble is loaded.
- rst asserted mid-stall or mid-flush: reset wins and the next cycle shows all zeros.
- taken_cnt at 8'hFF together with a taken-branch event: the count stays 8'hFF.
- Back-to-back stalls hold indefinitely with no loss of data.

## Configuration
- Macro: EX_MEM_BRANCH_SQUASH_EN.
- Defined: the block squashes the wrong-path instruction itself. On any taken-branch event, the incoming EX entry is replaced by a bubble, with exactly the same result as flush=1 for that edge.
- Not defined: the block squashes nothing on its own. Bubbles come only from the flush input, and on a taken branch the incoming entry loads normally.
- taken_cnt behaviour is identical with and without the macro.

## Test plan
- Reset: drive rst=1 for 2 cycles with non-zero inputs -> all outputs are 0 and taken_cnt=0.
- Normal load: aluout=32'h0000_00A5, muxout=5'd9, ctlwb_out=2'b10, valid_in=1 -> one edge later alu_result=32'h0000_00A5, five_bit_muxout=9, wb_ctlout=2'b10, valid_out=1.
- Stall: load an entry, then assert stall=1 for 3 cycles while the inputs change -> the outputs keep the first entry's values; deasserting stall loads the current inputs.
- Flush priority: stall=1 and flush=1 together -> next cycle valid_out=0, ctl bits 0, data fields 0.
- Branch taken: load ctlm_out=3'b100, aluzero=1, valid_in=1 -> m_ctlout=1 and zero=1 next cycle. On the following non-stalled edge, taken_cnt goes 0 -> 1. With EX_MEM_BRANCH_SQUASH_EN defined, that edge loads a bubble (valid_out=0); without it, the incoming entry loads normally.
- Saturation: generate 260 taken-branch events -> taken_cnt reaches 8'hFF and stays at 8'hFF.
